// File: rtl/rv_multicycle_seq.sv
// rv_multicycle_seq
//   Multicycle control sequencer for an RV64I datapath. Walks each instruction
//   through fetch / decode / execute / memory / writeback, drives the datapath
//   enables, resolves branches and jumps into a PC-source select, counts retired
//   instructions and traps on illegal opcodes.
//
//   Optional build macro: RV_SEQ_MEM_TIMEOUT_EN
//     When defined, an 8-bit watchdog counts consecutive not-ready cycles in
//     FETCH or MEM and forces TRAP after TIMEOUT_CYC of them.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     opcode, funct3        instruction fields from the instruction register
//     alu_zero, alu_lt      ALU flags used for branch resolution
//     imem_ready            instruction memory data valid
//     dmem_ready            data memory access complete
//     imem_req, ir_we       fetch request, instruction register load
//     pc_we, pc_src         PC update and source (0 pc+4, 1 pc+imm, 2 ALU&~1)
//     alu_src_b, alu_op     ALU B select (0 rs2, 1 imm) and operation class
//     dmem_req, dmem_we     data memory request / write
//     rf_we, wb_sel         register write and source (0 ALU, 1 mem, 2 pc+4)
//     state                 current state (debug)
//     illegal               sticky illegal-instruction flag
//     instret               retired-instruction count
//
//   state  | meaning
//   -------+----------------------------------------------
//   FETCH  | request instruction, load IR when ready
//   DECODE | latch opcode/funct3, check legality
//   EXEC   | drive ALU controls, resolve branches
//   MEM    | data memory access, wait for dmem_ready
//   WB     | register write and PC update
//   TRAP   | illegal instruction, held until reset
module rv_multicycle_seq #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            alu_zero,
  input  logic            alu_lt,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  output logic            imem_req,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            alu_src_b,
  output logic [1:0]      alu_op,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [2:0]      state,
  output logic            illegal,
  output logic [XLEN-1:0] instret
);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("rv_multicycle_seq: TIMEOUT_CYC must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t          state_q, state_nxt;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic            illegal_q;
  logic [XLEN-1:0] instret_q;
  logic            op_legal;
  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic            is_reg, is_arith;
  logic            br_taken, br_bad;
  logic            timeout_hit;

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_R, OP_I, OP_RW, OP_IW, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  assign is_load   = (op_q == OP_LOAD);
  assign is_store  = (op_q == OP_STORE);
  assign is_branch = (op_q == OP_BRANCH);
  assign is_jal    = (op_q == OP_JAL);
  assign is_jalr   = (op_q == OP_JALR);
  assign is_lui    = (op_q == OP_LUI);
  assign is_reg    = (op_q == OP_R) || (op_q == OP_RW);
  assign is_arith  = is_reg || (op_q == OP_I) || (op_q == OP_IW);

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (f3_q)
      3'b000:         br_taken = alu_zero;
      3'b001:         br_taken = !alu_zero;
      3'b100, 3'b110: br_taken = alu_lt;
      3'b101, 3'b111: br_taken = !alu_lt;
      default:        br_bad   = 1'b1;
    endcase
  end

`ifdef RV_SEQ_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       waiting;
  assign waiting     = ((state_q == S_FETCH) && !imem_ready) ||
                       ((state_q == S_MEM) && !dmem_ready);
  // Trap on the wait cycle that would take the count to the limit.
  assign timeout_hit = waiting && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_src_b = 1'b0;
    alu_op    = 2'd0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: state_nxt = op_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_src_b = !(is_reg || is_branch);
        alu_op    = is_branch ? 2'd1 : is_lui ? 2'd3 : is_arith ? 2'd2 : 2'd0;
        if (is_branch) begin
          if (br_bad) begin
            state_nxt = S_TRAP;
          end else begin
            pc_we     = 1'b1;
            pc_src    = br_taken ? 2'd1 : 2'd0;
            state_nxt = S_FETCH;
          end
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timeout_hit) begin
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        pc_we     = 1'b1;
        wb_sel    = is_load ? 2'd1 : (is_jal || is_jalr) ? 2'd2 : 2'd0;
        pc_src    = is_jal ? 2'd1 : is_jalr ? 2'd2 : 2'd0;
        state_nxt = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
    // Reset kills the in-flight instruction: nothing may commit this cycle.
    if (reset) begin
      imem_req  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 2'd0;
      alu_src_b = 1'b0;
      alu_op    = 2'd0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      f3_q      <= '0;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
      end
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
      if (pc_we) instret_q <= instret_q + {{(XLEN-1){1'b0}}, 1'b1};
    end
`ifdef RV_SEQ_MEM_TIMEOUT_EN
    if (reset || !waiting) wait_cnt <= '0;
    else                   wait_cnt <= wait_cnt + 8'd1;
`endif
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule
